// File: rtl/qmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// qmem_arbiter_pkg
// Shared definitions for the two-master QMEM arbiter: the 1-bit master index
// type, the index constants and the reset value of the round-robin history.
// No ports (package).
// -----------------------------------------------------------------------------
package qmem_arbiter_pkg;

  // Index of a master on the arbiter (two masters -> one bit).
  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  // "Most recently completed" master after reset. Pointing it at master 1
  // makes master 0 win the very first tie.
  localparam mst_idx_t LAST_RST = MST1;

endpackage : qmem_arbiter_pkg

// File: rtl/qmem_rr_pick.sv
// -----------------------------------------------------------------------------
// qmem_rr_pick
// Two-input round-robin pick with transfer lock. Purely combinational.
//
// Ports:
//   i_req[1:0]  request (chip-select) of master 1 / master 0
//   i_last      master that most recently completed a transfer
//   i_lock      a transfer is in progress with wait states
//   i_owner     master holding the lock
//   o_vld       a master is granted
//   o_gnt       index of the granted master (MST0 when o_vld=0)
// -----------------------------------------------------------------------------
module qmem_rr_pick
  import qmem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_lock,
  input  logic       i_owner,
  output logic       o_vld,
  output mst_idx_t   o_gnt
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    o_vld = 1'b0;
    o_gnt = MST0;
    if (i_lock) begin
      o_vld = 1'b1;
      o_gnt = i_owner;
    end else begin
      unique case (i_req)
        2'b01: begin
          o_vld = 1'b1;
          o_gnt = MST0;
        end
        2'b10: begin
          o_vld = 1'b1;
          o_gnt = MST1;
        end
        2'b11: begin
          // Tie: the master that did not complete last goes next.
          o_vld = 1'b1;
          o_gnt = ~i_last;
        end
        default: begin
          o_vld = 1'b0;
          o_gnt = MST0;
        end
      endcase
    end
  end

endmodule : qmem_rr_pick

// File: rtl/qmem_arbiter.sv
// -----------------------------------------------------------------------------
// qmem_arbiter
// Two-master to one-slave QMEM arbiter, round-robin, zero added latency.
// The grant is locked from the first wait-state cycle of a transfer until the
// slave answers with ack or err, so the slave sees stable request signals.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   m0_* / m1_*                  QMEM master ports (cs, we, sel, adr, dat_w in;
//                                dat_r, ack, err out)
//   qs_*                         QMEM slave port (cs, we, sel, adr, dat_w out;
//                                dat_r, ack, err in)
// -----------------------------------------------------------------------------
module qmem_arbiter
  import qmem_arbiter_pkg::*;
#(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8
) (
  input  logic           clk,
  input  logic           rst_n,
  // master 0
  input  logic           m0_cs,
  input  logic           m0_we,
  input  logic [QSW-1:0] m0_sel,
  input  logic [QAW-1:0] m0_adr,
  input  logic [QDW-1:0] m0_dat_w,
  output logic [QDW-1:0] m0_dat_r,
  output logic           m0_ack,
  output logic           m0_err,
  // master 1
  input  logic           m1_cs,
  input  logic           m1_we,
  input  logic [QSW-1:0] m1_sel,
  input  logic [QAW-1:0] m1_adr,
  input  logic [QDW-1:0] m1_dat_w,
  output logic [QDW-1:0] m1_dat_r,
  output logic           m1_ack,
  output logic           m1_err,
  // slave
  output logic           qs_cs,
  output logic           qs_we,
  output logic [QSW-1:0] qs_sel,
  output logic [QAW-1:0] qs_adr,
  output logic [QDW-1:0] qs_dat_w,
  input  logic [QDW-1:0] qs_dat_r,
  input  logic           qs_ack,
  input  logic           qs_err
);

  logic     r_lock;
  mst_idx_t r_owner;
  mst_idx_t r_last;

  logic     w_gnt_vld;
  mst_idx_t w_gnt;
  logic     w_done;

  // The grant is a function of state and chip-selects only; qs_ack/qs_err
  // never reach it, so a slave that acks combinationally cannot form a loop.
  qmem_rr_pick u_pick (
    .i_req   ({m1_cs, m0_cs}),
    .i_last  (r_last),
    .i_lock  (r_lock),
    .i_owner (r_owner),
    .o_vld   (w_gnt_vld),
    .o_gnt   (w_gnt)
  );

  // Without a grant w_gnt is MST0, so the slave sees master 0's signals with
  // qs_cs low. A locked owner that drops cs also yields qs_cs low.
  assign qs_cs    = w_gnt_vld & ((w_gnt == MST1) ? m1_cs : m0_cs);
  assign qs_we    = (w_gnt == MST1) ? m1_we    : m0_we;
  assign qs_sel   = (w_gnt == MST1) ? m1_sel   : m0_sel;
  assign qs_adr   = (w_gnt == MST1) ? m1_adr   : m0_adr;
  assign qs_dat_w = (w_gnt == MST1) ? m1_dat_w : m0_dat_w;

  assign m0_ack   = qs_ack & qs_cs & (w_gnt == MST0);
  assign m0_err   = qs_err & qs_cs & (w_gnt == MST0);
  assign m1_ack   = qs_ack & qs_cs & (w_gnt == MST1);
  assign m1_err   = qs_err & qs_cs & (w_gnt == MST1);

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_r = qs_dat_r;
  assign m1_dat_r = qs_dat_r;

  assign w_done   = qs_cs & (qs_ack | qs_err);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_lock  <= 1'b0;
      r_owner <= MST0;
      r_last  <= LAST_RST;
    end else if (w_done) begin
      r_lock  <= 1'b0;
      r_last  <= w_gnt;
    end else if (qs_cs) begin
      // Slave inserted a wait state: hold the grant until ack/err.
      r_lock  <= 1'b1;
      r_owner <= w_gnt;
    end else if (r_lock) begin
      // Locked owner abandoned its request; free the bus, history unchanged.
      r_lock  <= 1'b0;
    end
  end

endmodule : qmem_arbiter

// File: tb/tb_qmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qmem_arbiter
// Scoreboard bench for qmem_arbiter. Directed stimulus pushes the expected
// responses (with their cycle offset from the start of each scenario) into a
// queue; an independent monitor pops and compares whenever a master sees
// ack or err. A second monitor checks that the slave request stays stable
// across wait states. A small slave model answers after slv_wait cycles and
// raises err for addresses with adr[15:12] == 4'hE.
// -----------------------------------------------------------------------------
module tb_qmem_arbiter;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           m0_cs, m0_we, m1_cs, m1_we;
  logic [QSW-1:0] m0_sel, m1_sel;
  logic [QAW-1:0] m0_adr, m1_adr;
  logic [QDW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
  logic           m0_ack, m0_err, m1_ack, m1_err;
  logic           qs_cs, qs_we;
  logic [QSW-1:0] qs_sel;
  logic [QAW-1:0] qs_adr;
  logic [QDW-1:0] qs_dat_w, qs_dat_r;
  logic           qs_ack, qs_err;

  typedef struct {
    int          rel;    // cycle offset from scenario start
    logic [3:0]  flags;  // {m1_err, m1_ack, m0_err, m0_ack}
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t0       = 0;
  int          slv_wait = 0;
  int          slv_cnt;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_hit, slv_is_err;
  int          left0 = 0;
  int          left1 = 0;

  qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_cs    (m0_cs),
    .m0_we    (m0_we),
    .m0_sel   (m0_sel),
    .m0_adr   (m0_adr),
    .m0_dat_w (m0_dat_w),
    .m0_dat_r (m0_dat_r),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m1_cs    (m1_cs),
    .m1_we    (m1_we),
    .m1_sel   (m1_sel),
    .m1_adr   (m1_adr),
    .m1_dat_w (m1_dat_w),
    .m1_dat_r (m1_dat_r),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .qs_cs    (qs_cs),
    .qs_we    (qs_we),
    .qs_sel   (qs_sel),
    .qs_adr   (qs_adr),
    .qs_dat_w (qs_dat_w),
    .qs_dat_r (qs_dat_r),
    .qs_ack   (qs_ack),
    .qs_err   (qs_err)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  always_comb begin
    slv_is_err = (qs_adr[15:12] == 4'hE);
    slv_hit    = rst_n && qs_cs && (slv_cnt == slv_wait);
    qs_ack     = slv_hit && !slv_is_err;
    qs_err     = slv_hit && slv_is_err;
    qs_dat_r   = slv_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            slv_cnt <= 0;
    else if (qs_cs && !qs_ack && !qs_err)  slv_cnt <= slv_cnt + 1;
    else                                   slv_cnt <= 0;
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int rel, input logic [3:0] flags, input logic [31:0] adr,
                      input logic we, input logic [3:0] sel, input logic [31:0] wdat,
                      input logic [31:0] rdat);
    exp_t e;
    e.rel = rel; e.flags = flags; e.adr = adr; e.we = we;
    e.sel = sel; e.wdat = wdat; e.rdat = rdat;
    exp_q.push_back(e);
  endtask

  task automatic set_m0(input logic [31:0] adr, input logic we, input logic [31:0] wdat, input int n);
    m0_adr = adr; m0_we = we; m0_dat_w = wdat; left0 = n; m0_cs = (n > 0);
  endtask

  task automatic set_m1(input logic [31:0] adr, input logic we, input logic [31:0] wdat, input int n);
    m1_adr = adr; m1_we = we; m1_dat_w = wdat; left1 = n; m1_cs = (n > 0);
  endtask

  // One clock: note completions at the negedge, update requests after posedge.
  task automatic tick();
    logic d0, d1;
    @(negedge clk);
    d0 = m0_ack | m0_err;
    d1 = m1_ack | m1_err;
    @(posedge clk);
    #1;
    if (d0 && left0 > 0) left0--;
    if (d1 && left1 > 0) left1--;
    m0_cs = (left0 > 0);
    m1_cs = (left1 > 0);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((left0 > 0 || left1 > 0 || exp_q.size() > 0) && n < max) begin
      tick();
      n++;
    end
    if (left0 > 0 || left1 > 0 || exp_q.size() > 0) begin
      check("drain_timeout_pending", 32'(exp_q.size() + left0 + left1), 32'd0);
      exp_q.delete();
      left0 = 0; left1 = 0; m0_cs = 1'b0; m1_cs = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    left0 = 0; left1 = 0; m0_cs = 1'b0; m1_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- response monitor ----------------
  initial begin
    exp_t        e;
    logic [3:0]  fl;
    logic        pend;
    logic [31:0] p_adr, p_dat;
    logic        p_we;
    logic [3:0]  p_sel;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      fl = {m1_err, m1_ack, m0_err, m0_ack};
      if (fl != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp_flags", 32'(fl), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_flags", 32'(fl), 32'(e.flags));
          check("resp_cycle", 32'(cyc - t0), 32'(e.rel));
          check("resp_qs_adr", qs_adr, e.adr);
          check("resp_qs_we", 32'(qs_we), 32'(e.we));
          check("resp_qs_sel", 32'(qs_sel), 32'(e.sel));
          check("resp_qs_dat_w", qs_dat_w, e.wdat);
          if (e.flags[0] || e.flags[2])
            check("resp_dat_r", (fl[3] | fl[2]) ? m1_dat_r : m0_dat_r, e.rdat);
        end
      end
      // Request must not move while the slave is still working on it.
      if (pend && rst_n && qs_cs) begin
        check("stable_qs_adr", qs_adr, p_adr);
        check("stable_qs_dat_w", qs_dat_w, p_dat);
        check("stable_qs_we_sel", {27'd0, qs_we, qs_sel}, {27'd0, p_we, p_sel});
      end
      pend  = rst_n && qs_cs && !qs_ack && !qs_err;
      p_adr = qs_adr; p_dat = qs_dat_w; p_we = qs_we; p_sel = qs_sel;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    m0_cs = 1'b0; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = '0; m0_dat_w = '0;
    m1_cs = 1'b0; m1_we = 1'b0; m1_sel = 4'h3; m1_adr = '0; m1_dat_w = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: nothing requested, nothing granted; tie goes to master 0.
    check("rst_qs_cs_idle", 32'(qs_cs), 32'd0);
    check("rst_resp_idle", 32'({m1_err, m1_ack, m0_err, m0_ack}), 32'd0);
    m0_adr = 32'hA0; m1_adr = 32'hB0; m0_cs = 1'b1; m1_cs = 1'b1;
    #1;
    check("rst_tie_qs_cs", 32'(qs_cs), 32'd1);
    check("rst_tie_qs_adr", qs_adr, 32'hA0);
    m0_cs = 1'b0; m1_cs = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // S1: single zero-wait read from master 0.
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF;
    push(0, 4'b0001, 32'h100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
    t0 = cyc;
    set_m0(32'h100, 1'b0, 32'h0, 1);
    drain(20);

    // S1b: master 0 completed last, so a tie now goes to master 1.
    push(0, 4'b0100, 32'h204, 1'b0, 4'h3, 32'h0, 32'hDEAD_BEEF);
    push(1, 4'b0001, 32'h104, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
    t0 = cyc;
    set_m0(32'h104, 1'b0, 32'h0, 1);
    set_m1(32'h204, 1'b0, 32'h0, 1);
    drain(20);

    // S2: after reset, both stream zero-wait reads: strict alternation.
    do_reset();
    slv_rdata = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(i, 4'b0001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h1234_5678);
      else            push(i, 4'b0100, 32'h2000, 1'b0, 4'h3, 32'h0, 32'h1234_5678);
    end
    t0 = cyc;
    set_m0(32'h1000, 1'b0, 32'h0, 3);
    set_m1(32'h2000, 1'b0, 32'h0, 3);
    drain(30);

    // S3: master 1 write with 3 wait states; master 0 arrives one cycle later.
    slv_wait = 3; slv_rdata = 32'h0BAD_F00D;
    push(3, 4'b0100, 32'h20, 1'b1, 4'h3, 32'h55AA, 32'h0BAD_F00D);
    push(7, 4'b0001, 32'h40, 1'b0, 4'hF, 32'h0,    32'h0BAD_F00D);
    t0 = cyc;
    set_m1(32'h20, 1'b1, 32'h55AA, 1);
    tick();
    set_m0(32'h40, 1'b0, 32'h0, 1);
    drain(40);

    // S4: error on master 0's transfer; master 1 goes next.
    do_reset();
    slv_wait = 1; slv_rdata = 32'h7777_0000;
    push(1, 4'b0010, 32'hE000, 1'b0, 4'hF, 32'h0, 32'h7777_0000);
    push(3, 4'b0100, 32'h500,  1'b0, 4'h3, 32'h0, 32'h7777_0000);
    t0 = cyc;
    set_m0(32'hE000, 1'b0, 32'h0, 1);
    set_m1(32'h500,  1'b0, 32'h0, 1);
    drain(30);

    // S5: reset while master 1 is locked in wait states.
    slv_wait = 3; slv_rdata = 32'hC0DE_0005;
    t0 = cyc;
    set_m1(32'h600, 1'b0, 32'h0, 1);
    tick();
    set_m0(32'h640, 1'b0, 32'h0, 1);
    tick();
    check("locked_m1_qs_adr", qs_adr, 32'h600);
    rst_n = 1'b0;
    #1;
    check("rst_mid_qs_cs", 32'(qs_cs), 32'd1);
    check("rst_mid_qs_adr", qs_adr, 32'h640);
    tick();
    tick();
    slv_wait = 0;
    push(0, 4'b0001, 32'h640, 1'b0, 4'hF, 32'h0, 32'hC0DE_0005);
    push(1, 4'b0100, 32'h600, 1'b0, 4'h3, 32'h0, 32'hC0DE_0005);
    rst_n = 1'b1;
    t0 = cyc;
    drain(20);

    // S6: locked owner master 0 drops cs without ack; master 1 takes over.
    slv_wait = 5; slv_rdata = 32'h0000_0800;
    push(8, 4'b0100, 32'h800, 1'b0, 4'h3, 32'h0, 32'h0000_0800);
    t0 = cyc;
    set_m0(32'h700, 1'b0, 32'h0, 1);
    tick();
    set_m1(32'h800, 1'b0, 32'h0, 1);
    #1;
    check("viol_locked_qs_adr", qs_adr, 32'h700);
    tick();
    left0 = 0; m0_cs = 1'b0;
    #1;
    check("viol_drop_qs_cs", 32'(qs_cs), 32'd0);
    tick();
    #1;
    check("viol_m1_qs_cs", 32'(qs_cs), 32'd1);
    check("viol_m1_qs_adr", qs_adr, 32'h800);
    drain(30);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_qmem_arbiter
